// File: rtl/alu_seq_core.sv
// alu_seq_core: handshaked unsigned ALU with iterative shift-add multiply and restoring divide
module alu_seq_core #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               dbz,
  output logic               busy
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  state_t            state_q;
  logic [W2-1:0]     acc_q, opnd_q, result_q, acc_d, fast_d;
  logic [WIDTH-1:0]  sh_q, sh_d, diff;
  logic [WIDTH:0]    trial;
  logic [2:0]        op_q;
  logic [CW-1:0]     cnt_q;
  logic              out_valid_q, busy_q, dbz_q, accept, dz, iter_op, ge;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign dbz       = dbz_q;
  assign result    = result_q;
  // acc_q is the product accumulator (mul) or partial remainder (div/rem); sh_q is the multiplier or the dividend/quotient shift register
  always_comb begin
    in_ready = state_q == IDLE && !rst;
    accept   = in_valid && in_ready;
    dz       = (op == 3'd3 || op == 3'd4) && b == '0;
    iter_op  = op == 3'd2 || ((op == 3'd3 || op == 3'd4) && !dz);
    fast_d   = op == 3'd0 ? W2'(a) + W2'(b) :
               op == 3'd1 ? W2'(a) - W2'(b) :
               op == 3'd5 ? W2'(a & b) :
               op == 3'd6 ? W2'(a | b) :
               op == 3'd7 ? W2'(a ^ b) : '1;
    trial    = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
    ge       = trial >= {1'b0, opnd_q[WIDTH-1:0]};
    diff     = trial[WIDTH-1:0] - opnd_q[WIDTH-1:0];
    acc_d    = op_q == 3'd2 ? (sh_q[0] ? acc_q + opnd_q : acc_q) : W2'(ge ? diff : trial[WIDTH-1:0]);
    sh_d     = op_q == 3'd2 ? sh_q >> 1 : {sh_q[WIDTH-2:0], ge};
  end
  // control FSM and datapath registers; the last iteration loads the result directly from the step logic
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      dbz_q       <= 1'b0;
      result_q    <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      sh_q        <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          op_q  <= op;
          cnt_q <= CW'(WIDTH);
          if (iter_op) begin
            state_q <= ITER;
            busy_q  <= 1'b1;
            acc_q   <= '0;
            sh_q    <= op == 3'd2 ? b : a;
            opnd_q  <= W2'(op == 3'd2 ? a : b);
          end else begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= fast_d;
            dbz_q       <= dz;
          end
        end
        ITER: begin
          acc_q  <= acc_d;
          sh_q   <= sh_d;
          opnd_q <= op_q == 3'd2 ? opnd_q << 1 : opnd_q;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            dbz_q       <= 1'b0;
            result_q    <= op_q == 3'd3 ? W2'(sh_d) : acc_d;
          end
        end
        DONE: if (out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: directed and randomized checks of alu_seq_core against an arithmetic reference model
module tb_alu_seq_core;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, dbz, busy;
  logic [W-1:0] a, b;
  logic [2:0] op;
  logic [2*W-1:0] result;
  int tests = 0;
  int fails = 0;

  alu_seq_core #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .dbz(dbz), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference: {dbz, result} straight from the arithmetic definitions
  function automatic logic [2*W:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned ux = x;
    int unsigned uy = y;
    int unsigned m = 1 << (2 * W);
    case (o)
      3'd0: return {1'b0, (2*W)'(ux + uy)};
      3'd1: return {1'b0, (2*W)'((ux + m - uy) % m)};
      3'd2: return {1'b0, (2*W)'(ux * uy)};
      3'd3: return uy == 0 ? {1'b1, {(2*W){1'b1}}} : {1'b0, (2*W)'(ux / uy)};
      3'd4: return uy == 0 ? {1'b1, {(2*W){1'b1}}} : {1'b0, (2*W)'(ux % uy)};
      3'd5: return {1'b0, (2*W)'(ux & uy)};
      3'd6: return {1'b0, (2*W)'(ux | uy)};
      default: return {1'b0, (2*W)'(ux ^ uy)};
    endcase
  endfunction

  function automatic bit is_iter(input logic [2:0] o, input logic [W-1:0] y);
    return o == 3'd2 || ((o == 3'd3 || o == 3'd4) && y != 0);
  endfunction

  // drive one request, scramble inputs after accept, and measure edges to out_valid and busy samples
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit poke,
                       output logic [2*W-1:0] r, output logic d, output int edges, output int bc, output int rdy_busy);
    int t = 0;
    while (in_ready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
    edges = 0; bc = 0; rdy_busy = 0;
    while (out_valid !== 1'b1 && edges < 50) begin
      bc += int'(busy === 1'b1);
      rdy_busy += int'(in_ready === 1'b1);
      if (poke) in_valid = 1'($urandom);
      @(posedge clk); #1; edges++;
    end
    in_valid = 1'b0;
    r = result; d = dbz;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests++; if (result !== '0) begin fails++; $display("FAIL reset_result got=%h exp=0", result); end
    tests++; if (busy !== 1'b0 || dbz !== 1'b0) begin fails++; $display("FAIL reset_busy_dbz got=%b%b exp=00", busy, dbz); end
    rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single_cycle();
    logic [2:0] ops [4] = '{3'd0, 3'd1, 3'd5, 3'd7};
    logic [W-1:0] xs [4] = '{8'd200, 8'd5, 8'hF0, 8'hFF};
    logic [W-1:0] ys [4] = '{8'd100, 8'd8, 8'h3C, 8'h0F};
    logic [2*W-1:0] exp [4] = '{16'h012C, 16'hFFFD, 16'h0030, 16'h00F0};
    logic [2*W-1:0] r; logic d; int e, bc, rb;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], xs[i], ys[i], 1'b0, r, d, e, bc, rb);
      tests++; if (r !== exp[i]) begin fails++; $display("FAIL single_result op=%0d got=%h exp=%h", ops[i], r, exp[i]); end
      tests++; if (d !== 1'b0) begin fails++; $display("FAIL single_dbz op=%0d got=%b exp=0", ops[i], d); end
      tests++; if (e !== 0) begin fails++; $display("FAIL single_latency op=%0d got=%0d extra edges exp=0", ops[i], e); end
    end
  endtask

  task automatic test_mul();
    logic [2*W-1:0] r; logic d; int e, bc, rb;
    issue(3'd2, 8'd255, 8'd255, 1'b1, r, d, e, bc, rb);
    tests++; if (r !== 16'hFE01) begin fails++; $display("FAIL mul_result got=%h exp=FE01", r); end
    tests++; if (e !== W) begin fails++; $display("FAIL mul_latency got=%0d exp=%0d", e, W); end
    tests++; if (bc !== W) begin fails++; $display("FAIL mul_busy_cycles got=%0d exp=%0d", bc, W); end
    tests++; if (rb !== 0) begin fails++; $display("FAIL mul_in_ready_during_iter got=%0d exp=0", rb); end
    issue(3'd2, 8'd0, 8'd77, 1'b0, r, d, e, bc, rb);
    tests++; if (r !== 16'h0000 || e !== W) begin fails++; $display("FAIL mul_zero got=%h/%0d exp=0000/%0d", r, e, W); end
  endtask

  task automatic test_divide();
    logic [2:0] ops [4] = '{3'd3, 3'd4, 3'd3, 3'd4};
    logic [W-1:0] xs [4] = '{8'd200, 8'd200, 8'd5, 8'd3};
    logic [W-1:0] ys [4] = '{8'd7, 8'd7, 8'd0, 8'd9};
    logic [2*W-1:0] exp [4] = '{16'h001C, 16'h0004, 16'hFFFF, 16'h0003};
    logic expd [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int expe [4] = '{W, W, 0, W};
    logic [2*W-1:0] r; logic d; int e, bc, rb;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], xs[i], ys[i], 1'b0, r, d, e, bc, rb);
      tests++; if (r !== exp[i]) begin fails++; $display("FAIL div_result case=%0d got=%h exp=%h", i, r, exp[i]); end
      tests++; if (d !== expd[i]) begin fails++; $display("FAIL div_dbz case=%0d got=%b exp=%b", i, d, expd[i]); end
      tests++; if (e !== expe[i]) begin fails++; $display("FAIL div_latency case=%0d got=%0d exp=%0d", i, e, expe[i]); end
    end
  endtask

  task automatic test_backpressure();
    int t = 0;
    while (in_ready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    out_ready = 1'b0; op = 3'd0; a = 8'd10; b = 8'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    op = 3'd0; a = 8'd7; b = 8'd8;
    for (int i = 0; i < 5; i++) begin
      tests++; if (out_valid !== 1'b1 || result !== 16'd30 || dbz !== 1'b0 || in_ready !== 1'b0) begin
        fails++; $display("FAIL bp_hold cyc=%0d got v=%b r=%h z=%b rdy=%b exp v=1 r=001e z=0 rdy=0", i, out_valid, result, dbz, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || result !== 16'd15) begin fails++; $display("FAIL bp_next_add got v=%b r=%h exp v=1 r=000f", out_valid, result); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [2*W-1:0] r; logic d; int e, bc, rb;
    logic [2:0] o; logic [W-1:0] x, y; logic [2*W:0] m;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom); x = W'($urandom);
      y = $urandom_range(0, 4) == 0 ? '0 : W'($urandom);
      m = model(o, x, y);
      issue(o, x, y, 1'($urandom), r, d, e, bc, rb);
      tests++; if (r !== m[2*W-1:0]) begin fails++; $display("FAIL rand_result op=%0d a=%0d b=%0d got=%h exp=%h", o, x, y, r, m[2*W-1:0]); end
      tests++; if (d !== m[2*W]) begin fails++; $display("FAIL rand_dbz op=%0d b=%0d got=%b exp=%b", o, y, d, m[2*W]); end
      tests++; if (e !== (is_iter(o, y) ? W : 0)) begin fails++; $display("FAIL rand_latency op=%0d got=%0d exp=%0d", o, e, is_iter(o, y) ? W : 0); end
      tests++; if (bc !== (is_iter(o, y) ? W : 0) || rb !== 0) begin fails++; $display("FAIL rand_busy op=%0d got busy=%0d rdy=%0d exp busy=%0d rdy=0", o, bc, rb, is_iter(o, y) ? W : 0); end
    end
  endtask

  task automatic test_async_reset();
    logic [2*W-1:0] r; logic d; int e, bc, rb;
    int t = 0;
    while (in_ready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    op = 3'd2; a = 8'd200; b = 8'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0 || result !== '0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      fails++; $display("FAIL async_reset got v=%b r=%h busy=%b rdy=%b exp 0 0000 0 0", out_valid, result, busy, in_ready);
    end
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL after_reset got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid); end
    issue(3'd0, 8'd1, 8'd1, 1'b0, r, d, e, bc, rb);
    tests++; if (r !== 16'h0002 || e !== 0) begin fails++; $display("FAIL after_reset_add got=%h/%0d exp=0002/0", r, e); end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_mul();
    test_divide();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
Parametrised, handshaked successor to the 4-bit ALU core.
- Operand width is configurable; operands 'a' and 'b' are unsigned; result is 2*WIDTH bits.
- The op field widens to 3 bits and adds remainder and logic ops; the low 2 op codes keep their existing meaning.
- Add, sub and logic ops complete in 1 cycle. Multiply, divide and remainder run on an iterative one-bit-per-cycle datapath.
- Sits between an issuing controller and a result consumer, with valid/ready on both sides.

Parameters:
WIDTH, 8, operand width in bits (>=2); result width is 2*WIDTH.

Ports:
clk  input  1  single clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
in_valid  input  1  operation request valid.
in_ready  output  1  block can accept a request.
a  input  WIDTH  operand A, unsigned.
b  input  WIDTH  operand B, unsigned.
op  input  3  000 add, 001 sub, 010 mul, 011 div, 100 rem, 101 and, 110 or, 111 xor.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
result  output  2*WIDTH  registered result.
dbz  output  1  divide-by-zero flag; meaningful while out_valid=1.
busy  output  1  iterative operation in progress.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; out_valid=0, result=0, dbz=0, busy=0; internal counter and operand registers cleared.
  - in_ready=0 while rst=1.
  - Reset mid-operation abandons the operation; no out_valid is produced for it.
- States:
  - IDLE: in_ready=1.
  - ITER: busy=1, in_ready=0.
  - DONE: out_valid=1, in_ready=0.
- Accept:
  - A request is accepted on a rising edge with in_valid=1 and in_ready=1.
  - a, b and op are captured at that edge; later changes are ignored.
  - in_valid while in_ready=0 is ignored; the producer holds the request.
- Single-cycle ops (add, sub, and, or, xor, and div/rem with b==0):
  - Accept edge goes IDLE->DONE with result loaded.
  - out_valid is visible in the cycle after accept (latency 1).
- Iterative ops (mul; div/rem with b!=0):
  - Accept edge goes IDLE->ITER with counter=WIDTH.
  - Each ITER edge performs one shift-add (mul) or one restoring-division step (div/rem), then decrements the counter.
  - The edge that completes step WIDTH loads result and goes ITER->DONE.
  - out_valid is first visible WIDTH cycles after the accept edge; busy is high for exactly WIDTH cycles.
- DONE:
  - result, dbz and out_valid are held stable until an edge with out_ready=1.
  - That edge goes DONE->IDLE; out_valid=0 and in_ready=1 from the following cycle.
  - No accept in DONE; minimum spacing between accepts is latency+1 cycles.
  - result keeps its last value in IDLE and ITER; only out_valid qualifies it.
- Arithmetic (all results 2*WIDTH bits):
  - add: zero-extended a+b; carry lands in bit WIDTH.
  - sub: (zero-extended a) - (zero-extended b) mod 2^(2*WIDTH); a<b wraps.
  - mul: full unsigned product, no truncation.
  - div: quotient floor(a/b), zero-extended.
  - rem: a mod b, zero-extended.
  - and/or/xor: bitwise, zero-extended.
- Divide-by-zero: div or rem with b==0 gives result = all ones (2*WIDTH bits) and dbz=1, latency 1. dbz=0 for every other op.
- Boundaries:
  - mul 0*x is still iterative with full WIDTH latency.
  - div with a<b gives quotient 0, remainder a.
  - in_valid and out_ready asserted simultaneously in DONE: only the DONE->IDLE transition occurs; the request is accepted on a later edge from IDLE.

Test Plan:
1. WIDTH=8, add a=200, b=100, out_ready=1 -> result=0x012C (300), dbz=0; out_valid high exactly 1 cycle after accept.
2. sub a=5, b=8 -> result=0xFFFD, latency 1; then and a=0xF0, b=0x3C -> 0x0030; xor a=0xFF, b=0x0F -> 0x00F0.
3. mul a=255, b=255 -> result=0xFE01 (65025); busy=1 and in_ready=0 for exactly 8 cycles; out_valid visible 8 cycles after accept; in_valid pulses during ITER ignored.
4. Divide group:
   - div 200/7 -> 0x001C (28), latency 8.
   - rem 200/7 -> 0x0004.
   - div 5/0 -> result=0xFFFF, dbz=1, latency 1.
   - rem 3/9 -> 0x0003.
5. Backpressure: hold out_ready=0 for 5 cycles after out_valid; assert in_valid with a new add -> result, dbz and out_valid stable, in_ready=0, no accept. Raise out_ready -> IDLE next cycle; new add accepted and correct.
6. Assert rst asynchronously (mid-cycle) at cycle 3 of a mul -> out_valid=0, result=0, busy=0 immediately. After deassert, in_ready=1; a following add 1+1 returns 0x0002 with no stale mul result.
